spm_rr_arbiter: RTL and testbench
=================================

// Module: spm_rr_arbiter
// PURPOSE
//  Shares one single_port_memory (comb. read, sync write) between NumPorts requesters.
//  Round-robin grant, one access per cycle, registered read response one cycle after accept.
//  Optional per-request lock keeps the memory with one port for bursts (e.g. tile load).
//  Sits between accelerator engines (DMA, PE array, host) and the memory instance.
// PARAMETERS
//  NumPorts      4     number of requesters (>=2)
//  DataWidth     8     memory data width
//  DataDepth     4096  memory depth
//  AddrWidth     (DataDepth<=1)?1:$clog2(DataDepth)  address width
//  MaxLockCycles 16    idle cycles a lock owner may hold the memory without a valid request
// PORTS
//  clk_i          in   1                   clock
//  rst_ni         in   1                   reset, asynchronous, active-low
//  req_valid_i    in   NumPorts            per-port request valid
//  req_ready_o    out  NumPorts            per-port grant; accept = valid & ready
//  req_we_i       in   NumPorts            1 = write, 0 = read
//  req_lock_i     in   NumPorts            hold the grant after this beat
//  req_addr_i     in   NumPorts x AddrWidth  per-port address
//  req_wdata_i    in   NumPorts x DataWidth  per-port write data (signed)
//  rsp_valid_o    out  NumPorts            one-cycle read-data strobe, per port
//  rsp_rdata_o    out  DataWidth           read data, shared, qualified by rsp_valid_o
//  mem_addr_o     out  AddrWidth           to memory
//  mem_we_o       out  1                   to memory
//  mem_wr_data_o  out  DataWidth           to memory
//  mem_rd_data_i  in   DataWidth           from memory (comb. read)
// BEHAVIOUR
//  Reset: rr pointer=0, state=UNLOCKED, owner=0, lock counter=0, rsp_valid_o=0, rsp_rdata_o=0.
//   Comb. outputs with no grant: req_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wr_data_o=0.
//  Grant (comb.): at most one bit of req_ready_o set, only for a valid port.
//   UNLOCKED: first valid port searching ptr, ptr+1, ... wrapping at NumPorts.
//   LOCKED:   only owner may be granted; all other ports ready=0.
//  Accepted beat: mem_addr_o/mem_we_o/mem_wr_data_o driven from granted port same cycle.
//   Write: memory updated at that clock edge; no response.
//   Read: mem_rd_data_i registered into rsp_rdata_o; rsp_valid_o[g]=1 for exactly next cycle.
//   Back-to-back reads give one response per cycle, in accept order.
//  Pointer: on accept in UNLOCKED with lock=0, ptr <= (g+1) mod NumPorts; else unchanged.
//  FSM UNLOCKED -> LOCKED: accepted beat with req_lock_i[g]=1; owner<=g, counter<=0.
//  FSM LOCKED -> LOCKED: owner beat with lock=1 (counter<=0); owner idle cycle (counter++).
//  FSM LOCKED -> UNLOCKED: owner beat with lock=0 (ptr<=owner+1), or counter reaches
//   MaxLockCycles-1 while owner idle (forced release, ptr<=owner+1).
//  Simultaneous: requests from non-granted ports are held (valid must stay, fields stable).
//  Read-after-write same address on consecutive cycles returns the new data.
//  Reset mid-operation: pending rsp_valid dropped, lock released; memory contents unaffected.
// STRUCTURE
//  Package spm_arb_pkg: arb_state_e {UNLOCKED, LOCKED}; port index typedef; default widths.
//  Sub-module rr_priority_pick: comb. one-hot pick of first set bit from a rotating start index.
//  Top: FSM, pointer/owner/lock-counter regs, request mux, response register.
// TESTING
//  1) All 4 ports read addr 0x010..0x013 continuously, ptr=0 -> grants 0,1,2,3,0; each rsp
//     arrives 1 cycle after its accept with rsp_valid_o one-hot to that port.
//  2) Port1 writes 0x7F to 0x100, port2 reads 0x100 next cycle -> rsp_rdata_o=0x7F.
//  3) Port2 bursts 8 reads with lock=1 (last lock=0) while ports 0,3 valid -> ports 0,3
//     ready=0 for 8 beats; afterwards next grant is port3.
//  4) Port0 locks then drops valid -> after 16 idle cycles lock force-released, port1 granted.
//  5) Only port3 valid with ptr=1 -> port3 granted same cycle (wrap search).
//  6) rst_ni low during locked read burst -> rsp_valid_o=0 immediately, UNLOCKED, ptr=0;
//     data written before reset still reads back.

Source files
------------

// File: rtl/spm_rr_arbiter_pkg.sv
// Shared types and defaults for the single-port-memory round-robin arbiter.
// The arbiter itself is parameterised; these defaults describe the standard 4-port instance.
package spm_arb_pkg;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

    localparam int unsigned DefNumPorts      = 32'd4;
    localparam int unsigned DefDataWidth     = 32'd8;
    localparam int unsigned DefDataDepth     = 32'd4096;
    localparam int unsigned DefMaxLockCycles = 32'd16;

    // Minimum index width, never zero so single-entry ranges still get a real bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    typedef logic [idx_width(DefNumPorts)-1:0] port_idx_t;

endpackage

// File: rtl/spm_rr_arbiter_pick.sv
// Combinational one-hot pick of the first set request bit, searching upward
// from a rotating start index and wrapping at NumPorts.
module rr_priority_pick #(
    parameter int unsigned NumPorts = 32'd4,
    parameter int unsigned IdxWidth = 32'd2
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [IdxWidth-1:0] start_i,
    output logic [NumPorts-1:0] gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    logic [IdxWidth-1:0] cand_s;

    // Walk ports start, start+1, ... and keep the first requester found.
    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand_s = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            cand_s = IdxWidth'((32'(start_i) + i) % NumPorts);
            if (!any_o && req_i[cand_s]) begin
                gnt_o[cand_s] = 1'b1;
                idx_o         = cand_s;
                any_o         = 1'b1;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/spm_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory (comb. read, sync write)
// between NumPorts requesters, with per-beat lock and a forced release on idle owners.
module spm_rr_arbiter
    import spm_arb_pkg::*;
#(
    parameter int unsigned NumPorts      = DefNumPorts,
    parameter int unsigned DataWidth     = DefDataWidth,
    parameter int unsigned DataDepth     = DefDataDepth,
    parameter int unsigned AddrWidth     = (DataDepth <= 32'd1) ? 32'd1 : $clog2(DataDepth),
    parameter int unsigned MaxLockCycles = DefMaxLockCycles
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_valid_i,
    output logic [NumPorts-1:0]                 req_ready_o,
    input  logic [NumPorts-1:0]                 req_we_i,
    input  logic [NumPorts-1:0]                 req_lock_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  req_addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  req_wdata_i,
    output logic [NumPorts-1:0]                 rsp_valid_o,
    output logic [DataWidth-1:0]                rsp_rdata_o,
    output logic [AddrWidth-1:0]                mem_addr_o,
    output logic                                mem_we_o,
    output logic [DataWidth-1:0]                mem_wr_data_o,
    input  logic [DataWidth-1:0]                mem_rd_data_i
);

    localparam int unsigned         IdxWidth  = idx_width(NumPorts);
    localparam int unsigned         CntWidth  = idx_width(MaxLockCycles) + 32'd1;
    localparam logic [IdxWidth-1:0] LastPort  = IdxWidth'(NumPorts - 32'd1);
    localparam logic [CntWidth-1:0] LockLimit = CntWidth'(MaxLockCycles - 32'd1);

    arb_state_e             state_r;
    logic [IdxWidth-1:0]    ptr_r;
    logic [IdxWidth-1:0]    owner_r;
    logic [CntWidth-1:0]    lock_cnt_r;
    logic [NumPorts-1:0]    rsp_valid_r;
    logic [DataWidth-1:0]   rsp_rdata_r;

    logic [NumPorts-1:0]    pick_gnt_s;
    logic [IdxWidth-1:0]    pick_idx_s;
    logic                   pick_any_s;
    logic [NumPorts-1:0]    gnt_s;
    logic [IdxWidth-1:0]    gnt_idx_s;
    logic [IdxWidth-1:0]    next_ptr_s;
    logic                   accept_s;
    logic                   rd_accept_s;

    rr_priority_pick #(
        .NumPorts (NumPorts),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .req_i   (req_valid_i),
        .start_i (ptr_r),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // Grant selection: a locked owner excludes everyone else, even while it is idle.
    always_comb begin
        gnt_s     = '0;
        gnt_idx_s = owner_r;
        accept_s  = 1'b0;
        case (state_r)
            LOCKED: begin
                if (req_valid_i[owner_r]) begin
                    gnt_s[owner_r] = 1'b1;
                    accept_s       = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                gnt_s     = pick_gnt_s;
                gnt_idx_s = pick_idx_s;
                accept_s  = pick_any_s;
            end
        endcase
    end

    // Pointer moves just past the port last served; in LOCKED that is the owner.
    always_comb begin
        if (gnt_idx_s == LastPort) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gnt_idx_s + IdxWidth'(1);
        end
    end

    // Memory request mux, quiet (all zero) when nothing is accepted.
    always_comb begin
        mem_addr_o    = '0;
        mem_we_o      = 1'b0;
        mem_wr_data_o = '0;
        if (accept_s) begin
            mem_addr_o    = req_addr_i[gnt_idx_s];
            mem_we_o      = req_we_i[gnt_idx_s];
            mem_wr_data_o = req_wdata_i[gnt_idx_s];
        end else begin
            mem_we_o = 1'b0;
        end
    end

    assign rd_accept_s = accept_s && !req_we_i[gnt_idx_s];

    // Arbitration FSM, pointer/owner/lock counter and the read response register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= UNLOCKED;
            ptr_r       <= '0;
            owner_r     <= '0;
            lock_cnt_r  <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= rd_accept_s ? gnt_s : '0;
            if (rd_accept_s) begin
                rsp_rdata_r <= mem_rd_data_i;
            end

            case (state_r)
                LOCKED: begin
                    if (accept_s) begin
                        lock_cnt_r <= '0;
                        if (!req_lock_i[owner_r]) begin
                            state_r <= UNLOCKED;
                            ptr_r   <= next_ptr_s;
                        end
                    end else if (lock_cnt_r == LockLimit) begin
                        // Owner idle too long: hand the memory back to the others.
                        state_r    <= UNLOCKED;
                        ptr_r      <= next_ptr_s;
                        lock_cnt_r <= '0;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + CntWidth'(1);
                    end
                end
                default: begin
                    if (accept_s) begin
                        if (req_lock_i[gnt_idx_s]) begin
                            state_r    <= LOCKED;
                            owner_r    <= gnt_idx_s;
                            lock_cnt_r <= '0;
                        end else begin
                            state_r <= UNLOCKED;
                            ptr_r   <= next_ptr_s;
                        end
                    end else begin
                        state_r <= UNLOCKED;
                    end
                end
            endcase
        end
    end

    assign req_ready_o = gnt_s;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;

endmodule

// File: tb/tb_spm_rr_arbiter.sv
// Self-checking bench for spm_rr_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of round-robin, lock and memory behaviour.
module tb_spm_rr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int MAXL  = 16;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic [N-1:0]           req_valid_i, req_ready_o, req_we_i, req_lock_i, rsp_valid_o;
    logic [N-1:0][AW-1:0]   req_addr_i;
    logic [N-1:0][DW-1:0]   req_wdata_i;
    logic [DW-1:0]          rsp_rdata_o, mem_wr_data_o, mem_rd_data_i;
    logic [AW-1:0]          mem_addr_o;
    logic                   mem_we_o;

    always #5 clk_i = ~clk_i;

    spm_rr_arbiter #(
        .NumPorts(N), .DataWidth(DW), .DataDepth(DEPTH), .AddrWidth(AW), .MaxLockCycles(MAXL)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_lock_i(req_lock_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wr_data_o(mem_wr_data_o),
        .mem_rd_data_i(mem_rd_data_i)
    );

    // The memory instance the arbiter fronts: combinational read, synchronous write.
    logic [DW-1:0] mem [DEPTH];
    assign mem_rd_data_i = mem[mem_addr_o];
    always @(posedge clk_i) if (mem_we_o) mem[mem_addr_o] <= mem_wr_data_o;

    // Reference model state
    int            m_ptr, m_owner, m_idle;
    bit            m_locked;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            pend_v;
    int            pend_p;
    logic [DW-1:0] pend_d;
    logic [N-1:0]  exp_gnt, exp_rsp_v;
    logic [DW-1:0] exp_rdata;
    int            exp_g;
    bit            exp_acc;
    int            vectors = 0;
    int            errors  = 0;

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 0;
        pend_v = 0; pend_p = 0; pend_d = '0;
    endtask

    task automatic model_eval();
        exp_gnt = '0; exp_acc = 0; exp_g = 0;
        if (m_locked) begin
            if (req_valid_i[m_owner]) begin exp_g = m_owner; exp_acc = 1; end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!exp_acc && req_valid_i[(m_ptr + i) % N]) begin
                    exp_g = (m_ptr + i) % N; exp_acc = 1;
                end
            end
        end
        if (exp_acc) exp_gnt[exp_g] = 1'b1;
        exp_rsp_v = '0;
        if (pend_v) exp_rsp_v[pend_p] = 1'b1;
        exp_rdata = pend_d;
    endtask

    task automatic model_commit();
        pend_v = exp_acc && !req_we_i[exp_g];
        if (pend_v) begin pend_p = exp_g; pend_d = ref_mem[req_addr_i[exp_g]]; end
        if (exp_acc && req_we_i[exp_g]) ref_mem[req_addr_i[exp_g]] = req_wdata_i[exp_g];
        if (!m_locked) begin
            if (exp_acc && req_lock_i[exp_g]) begin m_locked = 1; m_owner = exp_g; m_idle = 0; end
            else if (exp_acc) m_ptr = (exp_g + 1) % N;
        end else if (exp_acc) begin
            m_idle = 0;
            if (!req_lock_i[exp_g]) begin m_locked = 0; m_ptr = (m_owner + 1) % N; end
        end else begin
            m_idle++;
            if (m_idle == MAXL) begin m_locked = 0; m_idle = 0; m_ptr = (m_owner + 1) % N; end
        end
    endtask

    task automatic settle();  @(negedge clk_i); model_eval(); endtask
    task automatic advance(); model_commit(); @(posedge clk_i); #1; endtask

    task automatic idle_inputs();
        req_valid_i = '0; req_we_i = '0; req_lock_i = '0; req_addr_i = '0; req_wdata_i = '0;
    endtask

    task automatic set_port(input int p, input bit we, input bit lk, input int addr, input int wd);
        req_valid_i[p] = 1'b1; req_we_i[p] = we; req_lock_i[p] = lk;
        req_addr_i[p] = AW'(addr); req_wdata_i[p] = DW'(wd);
    endtask

    task automatic test_reset();
        idle_inputs(); rst_ni = 1'b0; model_reset();
        repeat (2) @(posedge clk_i);
        settle();
        vectors++;
        if (req_ready_o !== 4'b0000 || mem_we_o !== 1'b0 || mem_addr_o !== 12'h000 || mem_wr_data_o !== 8'h00) begin
            errors++; $display("FAIL reset_comb ready=%b we=%b addr=%h wd=%h want all zero", req_ready_o, mem_we_o, mem_addr_o, mem_wr_data_o);
        end
        vectors++;
        if (rsp_valid_o !== 4'b0000 || rsp_rdata_o !== 8'h00) begin
            errors++; $display("FAIL reset_rsp valid=%b rdata=%h want 0000/00", rsp_valid_o, rsp_rdata_o);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_rr_reads();
        idle_inputs();
        for (int p = 0; p < N; p++) set_port(p, 0, 0, 'h010 + p, 0);
        for (int k = 0; k < 8; k++) begin
            settle();
            vectors++;
            if (req_ready_o !== (4'b0001 << (k % 4)) || req_ready_o !== exp_gnt) begin
                errors++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready_o, exp_gnt);
            end
            vectors++;
            if (rsp_valid_o !== exp_rsp_v || (pend_v && rsp_rdata_o !== exp_rdata)) begin
                errors++; $display("FAIL rr_rsp k=%0d got=%b/%h want=%b/%h", k, rsp_valid_o, rsp_rdata_o, exp_rsp_v, exp_rdata);
            end
            advance();
        end
        idle_inputs(); settle();
        vectors++;
        if (rsp_valid_o !== 4'b1000 || rsp_rdata_o !== exp_rdata) begin
            errors++; $display("FAIL rr_last_rsp got=%b/%h want=1000/%h", rsp_valid_o, rsp_rdata_o, exp_rdata);
        end
        advance();
    endtask

    task automatic test_read_after_write();
        idle_inputs(); set_port(1, 1, 0, 'h100, 'h7F);
        settle();
        vectors++;
        if (req_ready_o !== 4'b0010 || mem_we_o !== 1'b1 || mem_addr_o !== 12'h100 || mem_wr_data_o !== 8'h7F) begin
            errors++; $display("FAIL raw_write ready=%b we=%b addr=%h wd=%h want 0010/1/100/7f", req_ready_o, mem_we_o, mem_addr_o, mem_wr_data_o);
        end
        advance();
        idle_inputs(); set_port(2, 0, 0, 'h100, 0);
        settle(); advance();
        idle_inputs(); settle();
        vectors++;
        if (rsp_valid_o !== 4'b0100 || rsp_rdata_o !== 8'h7F) begin
            errors++; $display("FAIL raw_read got=%b/%h want 0100/7f", rsp_valid_o, rsp_rdata_o);
        end
        advance();
    endtask

    task automatic test_lock_burst();
        idle_inputs(); set_port(1, 0, 0, 'h011, 0);
        settle(); advance();
        idle_inputs();
        set_port(0, 0, 0, 'h020, 0); set_port(3, 0, 0, 'h023, 0);
        for (int b = 0; b < 8; b++) begin
            set_port(2, 0, (b != 7), 'h200 + b, 0);
            settle();
            vectors++;
            if (req_ready_o !== 4'b0100 || req_ready_o !== exp_gnt) begin
                errors++; $display("FAIL lock_burst b=%0d got=%b want=0100", b, req_ready_o);
            end
            vectors++;
            if (rsp_valid_o !== exp_rsp_v || (pend_v && rsp_rdata_o !== exp_rdata)) begin
                errors++; $display("FAIL lock_rsp b=%0d got=%b/%h want=%b/%h", b, rsp_valid_o, rsp_rdata_o, exp_rsp_v, exp_rdata);
            end
            advance();
        end
        req_valid_i[2] = 1'b0;
        settle();
        vectors++;
        if (req_ready_o !== 4'b1000) begin
            errors++; $display("FAIL lock_after got=%b want=1000", req_ready_o);
        end
        advance();
        req_valid_i[3] = 1'b0;
        settle(); advance();
        idle_inputs(); settle(); advance();
    endtask

    task automatic test_lock_timeout();
        idle_inputs(); set_port(0, 1, 1, 'h040, 'h33);
        settle(); advance();
        idle_inputs(); set_port(1, 0, 0, 'h040, 0);
        for (int c = 0; c < MAXL; c++) begin
            settle();
            vectors++;
            if (req_ready_o !== 4'b0000 || req_ready_o !== exp_gnt) begin
                errors++; $display("FAIL lock_hold c=%0d got=%b want=0000", c, req_ready_o);
            end
            advance();
        end
        settle();
        vectors++;
        if (req_ready_o !== 4'b0010) begin
            errors++; $display("FAIL lock_release got=%b want=0010", req_ready_o);
        end
        advance();
        idle_inputs(); settle();
        vectors++;
        if (rsp_valid_o !== 4'b0010 || rsp_rdata_o !== 8'h33) begin
            errors++; $display("FAIL timeout_rsp got=%b/%h want=0010/33", rsp_valid_o, rsp_rdata_o);
        end
        advance();
    endtask

    task automatic test_wrap();
        idle_inputs(); set_port(0, 0, 0, 'h000, 0);
        settle(); advance();
        idle_inputs(); set_port(3, 0, 0, 'h013, 0);
        settle();
        vectors++;
        if (req_ready_o !== 4'b1000) begin
            errors++; $display("FAIL wrap_grant got=%b want=1000", req_ready_o);
        end
        advance();
        idle_inputs(); settle();
        vectors++;
        if (rsp_valid_o !== 4'b1000 || rsp_rdata_o !== exp_rdata) begin
            errors++; $display("FAIL wrap_rsp got=%b/%h want=1000/%h", rsp_valid_o, rsp_rdata_o, exp_rdata);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        idle_inputs(); set_port(1, 1, 0, 'h300, 'h5A);
        settle(); advance();
        idle_inputs(); set_port(2, 0, 1, 'h301, 0);
        settle(); advance();
        set_port(2, 0, 1, 'h302, 0);
        settle(); advance();
        vectors++;
        if (rsp_valid_o !== 4'b0100) begin
            errors++; $display("FAIL mid_pre_rsp got=%b want=0100", rsp_valid_o);
        end
        #2 rst_ni = 1'b0; idle_inputs(); model_reset();
        #1;
        vectors++;
        if (rsp_valid_o !== 4'b0000 || rsp_rdata_o !== 8'h00) begin
            errors++; $display("FAIL mid_reset_rsp got=%b/%h want=0000/00", rsp_valid_o, rsp_rdata_o);
        end
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        for (int p = 0; p < N; p++) set_port(p, 0, 0, 'h300 + p, 0);
        settle();
        vectors++;
        if (req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL mid_unlocked got=%b want=0001", req_ready_o);
        end
        advance();
        idle_inputs(); settle();
        vectors++;
        if (rsp_valid_o !== 4'b0001 || rsp_rdata_o !== 8'h5A) begin
            errors++; $display("FAIL mid_keep_data got=%b/%h want=0001/5a", rsp_valid_o, rsp_rdata_o);
        end
        advance();
    endtask

    task automatic test_random();
        int  g;
        bit  acc;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_valid_i[p] && $urandom_range(0, 2) == 0)
                    set_port(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                             int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            end
            settle();
            vectors++;
            if (req_ready_o !== exp_gnt) begin
                errors++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, req_ready_o, exp_gnt);
            end
            vectors++;
            if (rsp_valid_o !== exp_rsp_v || (pend_v && rsp_rdata_o !== exp_rdata)) begin
                errors++; $display("FAIL rnd_rsp c=%0d got=%b/%h want=%b/%h", c, rsp_valid_o, rsp_rdata_o, exp_rsp_v, exp_rdata);
            end
            if (exp_acc) begin
                vectors++;
                if (mem_we_o !== req_we_i[exp_g] || mem_addr_o !== req_addr_i[exp_g] ||
                    (req_we_i[exp_g] && mem_wr_data_o !== req_wdata_i[exp_g])) begin
                    errors++; $display("FAIL rnd_mem c=%0d got=%b/%h/%h port=%0d", c, mem_we_o, mem_addr_o, mem_wr_data_o, exp_g);
                end
            end
            g = exp_g; acc = exp_acc;
            advance();
            if (acc) req_valid_i[g] = 1'b0;
        end
        idle_inputs(); settle(); advance();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_rr_reads();
        test_read_after_write();
        test_lock_burst();
        test_lock_timeout();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
